// File: rtl/issue_queue_param_if.sv
// rtl/issue_queue_param_if.sv - dispatch, wakeup, issue and flush signal bundle for issue_queue_param
interface issue_queue_param_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              dispatch_enable;
    logic [OP_W-1:0]   dispatch_op;
    logic [TAG_W-1:0]  dispatch_rd_tag;
    logic [DATA_W-1:0] dispatch_rs_data;
    logic [DATA_W-1:0] dispatch_rt_data;
    logic [TAG_W-1:0]  dispatch_rs_tag;
    logic [TAG_W-1:0]  dispatch_rt_tag;
    logic              dispatch_rs_data_val;
    logic              dispatch_rt_data_val;
    logic              full;
    logic [OCC_W-1:0]  occupancy;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issueblk_issue;
    logic              issueque_ready;
    logic [OP_W-1:0]   issueque_op;
    logic [DATA_W-1:0] issueque_rs_data;
    logic [DATA_W-1:0] issueque_rt_data;
    logic [TAG_W-1:0]  issueque_rd_tag;
    logic              flush_valid;

    modport master (
        output dispatch_enable, dispatch_op, dispatch_rd_tag,
               dispatch_rs_data, dispatch_rt_data, dispatch_rs_tag, dispatch_rt_tag,
               dispatch_rs_data_val, dispatch_rt_data_val,
               cdb_valid, cdb_tag, cdb_data, issueblk_issue, flush_valid,
        input  full, occupancy, issueque_ready, issueque_op,
               issueque_rs_data, issueque_rt_data, issueque_rd_tag
    );

    modport slave (
        input  dispatch_enable, dispatch_op, dispatch_rd_tag,
               dispatch_rs_data, dispatch_rt_data, dispatch_rs_tag, dispatch_rt_tag,
               dispatch_rs_data_val, dispatch_rt_data_val,
               cdb_valid, cdb_tag, cdb_data, issueblk_issue, flush_valid,
        output full, occupancy, issueque_ready, issueque_op,
               issueque_rs_data, issueque_rt_data, issueque_rd_tag
    );
endinterface

// File: rtl/issue_queue_param.sv
// rtl/issue_queue_param.sv - compacting age-ordered issue queue with CDB wakeup (option: ISSUE_QUEUE_DISPATCH_BYPASS_EN)
module issue_queue_param #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 4
) (
    input logic                 clock,
    input logic                 nreset,
    issue_queue_param_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rd_tag;
        logic [DATA_W-1:0] rs_data;
        logic [TAG_W-1:0]  rs_tag;
        logic              rs_val;
        logic [DATA_W-1:0] rt_data;
        logic [TAG_W-1:0]  rt_tag;
        logic              rt_val;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic [OCC_W-1:0]  occ_after_issue;
    logic [DEPTH-1:0]  ready_vec;
    logic [IDX_W-1:0]  sel_idx;
    logic              any_ready;
    logic              full_w;
    logic              issue_fire;
    logic              accept;
    entry_t            sel_ent;
    entry_t            new_ent;

    // An entry is ready only from its registered operand flags, so a wakeup takes effect a cycle later
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = (OCC_W'(i) < occ_q) && ent_q[i].rs_val && ent_q[i].rt_val;
        end
    end

    // Scan youngest to oldest so the lowest ready index is the one left standing
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) sel_idx = IDX_W'(i);
        end
    end

    assign any_ready  = |ready_vec;
    assign sel_ent    = ent_q[sel_idx];
    assign full_w     = (occ_q == OCC_W'(DEPTH));
    assign issue_fire = bus.issueblk_issue && any_ready;
    assign accept     = bus.dispatch_enable && !full_w;

    assign bus.full             = full_w;
    assign bus.occupancy        = occ_q;
    assign bus.issueque_ready   = any_ready;
    assign bus.issueque_op      = any_ready ? sel_ent.op      : '0;
    assign bus.issueque_rs_data = any_ready ? sel_ent.rs_data : '0;
    assign bus.issueque_rt_data = any_ready ? sel_ent.rt_data : '0;
    assign bus.issueque_rd_tag  = any_ready ? sel_ent.rd_tag  : '0;

    // Build the incoming entry; with bypass, a same-cycle broadcast for a missing operand is captured here
    always_comb begin
        new_ent.op      = bus.dispatch_op;
        new_ent.rd_tag  = bus.dispatch_rd_tag;
        new_ent.rs_data = bus.dispatch_rs_data;
        new_ent.rs_tag  = bus.dispatch_rs_tag;
        new_ent.rs_val  = bus.dispatch_rs_data_val;
        new_ent.rt_data = bus.dispatch_rt_data;
        new_ent.rt_tag  = bus.dispatch_rt_tag;
        new_ent.rt_val  = bus.dispatch_rt_data_val;
`ifdef ISSUE_QUEUE_DISPATCH_BYPASS_EN
        if (bus.cdb_valid && !bus.dispatch_rs_data_val && (bus.dispatch_rs_tag == bus.cdb_tag)) begin
            new_ent.rs_data = bus.cdb_data;
            new_ent.rs_val  = 1'b1;
        end
        if (bus.cdb_valid && !bus.dispatch_rt_data_val && (bus.dispatch_rt_tag == bus.cdb_tag)) begin
            new_ent.rt_data = bus.cdb_data;
            new_ent.rt_val  = 1'b1;
        end
`endif
    end

    // Next state: compact out the issued entry, wake survivors, append the dispatch, zero the free tail
    always_comb begin
        occ_after_issue = occ_q - OCC_W'(issue_fire);
        occ_d           = occ_after_issue + OCC_W'(accept);
        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = (issue_fire && (IDX_W'(i) >= sel_idx)) ? ent_q[i+1] : ent_q[i];
        end
        ent_d[DEPTH-1] = issue_fire ? '0 : ent_q[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.cdb_valid && (OCC_W'(i) < occ_after_issue)) begin
                if (!ent_d[i].rs_val && (ent_d[i].rs_tag == bus.cdb_tag)) begin
                    ent_d[i].rs_data = bus.cdb_data;
                    ent_d[i].rs_val  = 1'b1;
                end
                if (!ent_d[i].rt_val && (ent_d[i].rt_tag == bus.cdb_tag)) begin
                    ent_d[i].rt_data = bus.cdb_data;
                    ent_d[i].rt_val  = 1'b1;
                end
            end
            if (accept && (OCC_W'(i) == occ_after_issue)) ent_d[i] = new_ent;
            if (OCC_W'(i) >= occ_d) ent_d[i] = '0;
        end
        if (bus.flush_valid) begin
            occ_d = '0;
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
        end
    end

    // Entry storage and occupancy; reset empties the queue immediately
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end
endmodule

// File: tb/tb_issue_queue_param.sv
// tb/tb_issue_queue_param.sv - randomized and directed checks of issue_queue_param against a queue model
module tb_issue_queue_param;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int OP_W   = 4;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rd;
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rt;
        logic              rsv;
        logic              rtv;
        logic [TAG_W-1:0]  rst;
        logic [TAG_W-1:0]  rtt;
    } m_ent_t;

    logic   clock = 1'b0;
    logic   nreset = 1'b0;
    int     checks = 0;
    int     errors = 0;
    m_ent_t mq[$];

    issue_queue_param_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

    issue_queue_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int sel = -1;
        logic [63:0] e_op = 0, e_rs = 0, e_rt = 0, e_rd = 0;
        for (int i = 0; i < mq.size(); i++)
            if (sel < 0 && mq[i].rsv && mq[i].rtv) sel = i;
        if (sel >= 0) begin
            e_op = 64'(mq[sel].op);
            e_rs = 64'(mq[sel].rs);
            e_rt = 64'(mq[sel].rt);
            e_rd = 64'(mq[sel].rd);
        end
        check({tag, ".occ"},   64'(bus.occupancy),        64'(mq.size()));
        check({tag, ".full"},  64'(bus.full),             64'(mq.size() == DEPTH));
        check({tag, ".ready"}, 64'(bus.issueque_ready),   64'(sel >= 0));
        check({tag, ".op"},    64'(bus.issueque_op),      e_op);
        check({tag, ".rs"},    64'(bus.issueque_rs_data), e_rs);
        check({tag, ".rt"},    64'(bus.issueque_rt_data), e_rt);
        check({tag, ".rd"},    64'(bus.issueque_rd_tag),  e_rd);
    endtask

    task automatic model_edge();
        int sel = -1;
        bit acc;
        m_ent_t n;
        if (!nreset || bus.flush_valid) begin
            mq.delete();
            return;
        end
        for (int i = 0; i < mq.size(); i++)
            if (sel < 0 && mq[i].rsv && mq[i].rtv) sel = i;
        acc = bus.dispatch_enable && (mq.size() < DEPTH);
        if (bus.cdb_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].rsv && mq[i].rst == bus.cdb_tag) begin mq[i].rs = bus.cdb_data; mq[i].rsv = 1'b1; end
                if (!mq[i].rtv && mq[i].rtt == bus.cdb_tag) begin mq[i].rt = bus.cdb_data; mq[i].rtv = 1'b1; end
            end
        end
        if (bus.issueblk_issue && sel >= 0) mq.delete(sel);
        if (acc) begin
            n.op = bus.dispatch_op;         n.rd = bus.dispatch_rd_tag;
            n.rs = bus.dispatch_rs_data;    n.rt = bus.dispatch_rt_data;
            n.rsv = bus.dispatch_rs_data_val; n.rtv = bus.dispatch_rt_data_val;
            n.rst = bus.dispatch_rs_tag;    n.rtt = bus.dispatch_rt_tag;
`ifdef ISSUE_QUEUE_DISPATCH_BYPASS_EN
            if (bus.cdb_valid && !n.rsv && n.rst == bus.cdb_tag) begin n.rs = bus.cdb_data; n.rsv = 1'b1; end
            if (bus.cdb_valid && !n.rtv && n.rtt == bus.cdb_tag) begin n.rt = bus.cdb_data; n.rtv = 1'b1; end
`endif
            mq.push_back(n);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        @(negedge clock);
        check_model(tag);
    endtask

    task automatic idle();
        bus.dispatch_enable = 0; bus.dispatch_op = 0; bus.dispatch_rd_tag = 0;
        bus.dispatch_rs_data = 0; bus.dispatch_rt_data = 0;
        bus.dispatch_rs_tag = 0; bus.dispatch_rt_tag = 0;
        bus.dispatch_rs_data_val = 0; bus.dispatch_rt_data_val = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.issueblk_issue = 0; bus.flush_valid = 0;
    endtask

    task automatic disp(input int op, input int rd, input int rs, input bit rsv, input int rst,
                        input int rt, input bit rtv, input int rtt);
        bus.dispatch_enable = 1;
        bus.dispatch_op = OP_W'(op);         bus.dispatch_rd_tag = TAG_W'(rd);
        bus.dispatch_rs_data = DATA_W'(rs);  bus.dispatch_rs_data_val = rsv; bus.dispatch_rs_tag = TAG_W'(rst);
        bus.dispatch_rt_data = DATA_W'(rt);  bus.dispatch_rt_data_val = rtv; bus.dispatch_rt_tag = TAG_W'(rtt);
    endtask

    task automatic flush_all();
        idle();
        bus.flush_valid = 1;
        step("flush");
        idle();
    endtask

    initial begin
        idle();
        #12;
        check_model("reset");
        @(negedge clock);
        nreset = 1;

        // single ready dispatch
        disp(3, 7, 'h10, 1, 0, 'h20, 1, 0);
        step("d024");
        idle();
        check("d024.ready", 64'(bus.issueque_ready), 64'd1);
        check("d024.rd",    64'(bus.issueque_rd_tag), 64'd7);
        check("d024.rs",    64'(bus.issueque_rs_data), 64'h10);
        check("d024.occ",   64'(bus.occupancy), 64'd1);
        bus.issueblk_issue = 1;
        step("d024_issue");
        idle();

        // fill with waiting entries, then a dropped fifth dispatch
        for (int i = 0; i < DEPTH; i++) begin
            disp(i, i + 1, 0, 0, 20, 0, 1, 0);
            step("d025_fill");
        end
        check("d025.full", 64'(bus.full), 64'd1);
        disp(9, 9, 1, 1, 0, 2, 1, 0);
        step("d025_drop");
        idle();
        check("d025.occ", 64'(bus.occupancy), 64'd4);
        flush_all();

        // wakeup of two entries on tag 9, oldest selected first
        disp(1, 1, 0, 0, 9, 'h11, 1, 0);  step("d026_e0");
        disp(2, 2, 0, 0, 12, 'h22, 1, 0); step("d026_e1");
        disp(3, 3, 0, 0, 9, 'h33, 1, 0);  step("d026_e2");
        idle();
        bus.cdb_valid = 1; bus.cdb_tag = 9; bus.cdb_data = 'hABCD; bus.issueblk_issue = 1;
        step("d026_wake");
        idle();
        check("d026.rd0", 64'(bus.issueque_rd_tag), 64'd1);
        check("d026.rs0", 64'(bus.issueque_rs_data), 64'hABCD);
        bus.issueblk_issue = 1;
        step("d026_issue");
        idle();
        check("d026.rd2", 64'(bus.issueque_rd_tag), 64'd3);
        check("d026.occ", 64'(bus.occupancy), 64'd2);
        flush_all();

        // full queue with issue and dispatch together
        for (int i = 0; i < DEPTH; i++) begin
            disp(i, i + 4, i, 1, 0, i, 1, 0);
            step("d027_fill");
        end
        disp(5, 15, 5, 1, 0, 5, 1, 0);
        bus.issueblk_issue = 1;
        step("d027_both");
        idle();
        check("d027.occ",  64'(bus.occupancy), 64'd3);
        check("d027.full", 64'(bus.full), 64'd0);
        flush_all();

        // dispatch racing its producer's broadcast
        disp(6, 6, 'h1, 0, 4, 'h2, 1, 0);
        bus.cdb_valid = 1; bus.cdb_tag = 4; bus.cdb_data = 'h55;
        step("d028");
        idle();
`ifdef ISSUE_QUEUE_DISPATCH_BYPASS_EN
        check("d028.ready", 64'(bus.issueque_ready), 64'd1);
        check("d028.rs",    64'(bus.issueque_rs_data), 64'h55);
`else
        check("d028.ready", 64'(bus.issueque_ready), 64'd0);
`endif
        flush_all();

        // flush overrides dispatch, issue and wakeup
        for (int i = 0; i < 3; i++) begin
            disp(i, i + 1, i, 1, 0, i, 1, 0);
            step("d029_fill");
        end
        disp(7, 8, 1, 0, 2, 1, 1, 0);
        bus.issueblk_issue = 1; bus.cdb_valid = 1; bus.cdb_tag = 2; bus.flush_valid = 1;
        step("d029_flush");
        idle();
        check("d029.occ",   64'(bus.occupancy), 64'd0);
        check("d029.ready", 64'(bus.issueque_ready), 64'd0);
        check("d029.rs",    64'(bus.issueque_rs_data), 64'd0);

        // randomized traffic with one asynchronous reset in the middle
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) begin
                idle();
                #2 nreset = 0;
                #1;
                mq.delete();
                check_model("async_rst");
                @(negedge clock);
                check_model("held_rst");
                nreset = 1;
            end
            bus.dispatch_enable      = ($urandom_range(0, 1) == 1);
            bus.dispatch_op          = OP_W'($urandom);
            bus.dispatch_rd_tag      = TAG_W'($urandom);
            bus.dispatch_rs_data     = DATA_W'($urandom);
            bus.dispatch_rt_data     = DATA_W'($urandom);
            bus.dispatch_rs_tag      = TAG_W'($urandom_range(0, 7));
            bus.dispatch_rt_tag      = TAG_W'($urandom_range(0, 7));
            bus.dispatch_rs_data_val = ($urandom_range(0, 1) == 1);
            bus.dispatch_rt_data_val = ($urandom_range(0, 1) == 1);
            bus.cdb_valid            = ($urandom_range(0, 1) == 1);
            bus.cdb_tag              = TAG_W'($urandom_range(0, 7));
            bus.cdb_data             = DATA_W'($urandom);
            bus.issueblk_issue       = ($urandom_range(0, 9) < 6);
            bus.flush_valid          = ($urandom_range(0, 31) == 0);
            step("rand");
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
